// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// State and owner values are fixed so they can be read directly on debug probes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_FETCH = 2'b01,
        OWN_DATA  = 2'b10
    } owner_e;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int STARVE_W = 4;

    // A timed-out access returns this bit replicated across the data width.
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner select: data wins unless the starvation guard hands
// the slot to a waiting fetch.
module mem_arb_priority (
    input  logic i_req,
    input  logic d_req,
    input  logic starve_hit,
    output logic win_i,
    output logic win_d
);

    assign win_d = d_req & ~(starve_hit & i_req);
    assign win_i = i_req & ~win_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Each access runs IDLE -> GRANT -> RESP, so the port turns over every 3+ cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        owner,
    output logic              err
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e          state_q,   state_d;
    owner_e              owner_q,   owner_d;
    logic [ADDR_W-1:0]   m_addr_q,  m_addr_d;
    logic                m_we_q,    m_we_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [STARVE_W-1:0] starve_q,  starve_d;
    logic [TO_W-1:0]     to_cnt_q,  to_cnt_d;
    logic                err_q,     err_d;

    logic starve_hit;
    logic win_i;
    logic win_d;

    assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));

    mem_arb_priority u_priority (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_hit (starve_hit),
        .win_i      (win_i),
        .win_d      (win_d)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_addr_d  = m_addr_q;
        m_we_d    = m_we_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_d) begin
                    state_d   = ST_GRANT_D;
                    owner_d   = OWN_DATA;
                    m_addr_d  = d_addr;
                    m_we_d    = d_we;
                    m_wdata_d = d_wdata;
                    // Only data grants that bypass a waiting fetch count toward starvation.
                    if (!i_req) begin
                        starve_d = '0;
                    end else if (!starve_hit) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (win_i) begin
                    state_d   = ST_GRANT_I;
                    owner_d   = OWN_FETCH;
                    m_addr_d  = i_addr;
                    m_we_d    = 1'b0;
                    m_wdata_d = '0;
                    starve_d  = '0;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (m_ready) begin
                    state_d = ST_RESP;
                    if (state_q == ST_GRANT_I) begin
                        i_rdata_d = m_rdata;
                    end else if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    // Give up on a stuck memory but still retire the requester.
                    if ((TIMEOUT != 0) && (to_cnt_d == TO_W'(TIMEOUT))) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        if (state_q == ST_GRANT_I) begin
                            i_rdata_d = {DATA_W{TIMEOUT_FILL_BIT}};
                        end else if (!m_we_q) begin
                            d_rdata_d = {DATA_W{TIMEOUT_FILL_BIT}};
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                owner_d  = OWN_NONE;
                to_cnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
        end
    end

    assign m_valid = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ready = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
    assign d_ready = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign owner   = owner_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic, all compared each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          m_valid;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    owner;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (SL),
        .TIMEOUT      (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .m_valid (m_valid),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .owner   (owner),
        .err     (err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which requester holds the memory, how long it has
    // waited, and whether its retire cycle is in progress.
    int            mdl_own = 0;
    int            mdl_wait = 0;
    bit            mdl_resp = 1'b0;
    int            mdl_starve = 0;
    logic [AW-1:0] exp_addr = '0;
    logic          exp_we = 1'b0;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] exp_irdata = '0;
    logic [DW-1:0] exp_drdata = '0;
    logic          exp_err = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mdl_own = 0; mdl_wait = 0; mdl_resp = 1'b0; mdl_starve = 0;
            exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
            exp_irdata = '0; exp_drdata = '0; exp_err = 1'b0;
        end else if (mdl_resp) begin
            mdl_resp = 1'b0;
            mdl_own = 0;
            mdl_wait = 0;
        end else if (mdl_own != 0) begin
            if (m_ready) begin
                if (mdl_own == 1) exp_irdata = m_rdata;
                else if (!exp_we) exp_drdata = m_rdata;
                mdl_resp = 1'b1;
            end else begin
                mdl_wait++;
                if (TO != 0 && mdl_wait == TO) begin
                    exp_err = 1'b1;
                    if (mdl_own == 1) exp_irdata = '1;
                    else if (!exp_we) exp_drdata = '1;
                    mdl_resp = 1'b1;
                end
            end
        end else if (d_req && !(i_req && mdl_starve == SL)) begin
            mdl_own = 2;
            exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata;
            mdl_starve = i_req ? ((mdl_starve < SL) ? mdl_starve + 1 : SL) : 0;
        end else if (i_req) begin
            mdl_own = 1;
            exp_addr = i_addr; exp_we = 1'b0; exp_wdata = '0;
            mdl_starve = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("m_valid", m_valid, (mdl_own != 0 && !mdl_resp));
            check_output("owner", owner, mdl_own);
            check_output("i_ready", i_ready, (mdl_resp && mdl_own == 1));
            check_output("d_ready", d_ready, (mdl_resp && mdl_own == 2));
            check_output("m_addr", m_addr, exp_addr);
            check_output("m_we", m_we, exp_we);
            check_output("m_wdata", m_wdata, exp_wdata);
            check_output("i_rdata", i_rdata, exp_irdata);
            check_output("d_rdata", d_rdata, exp_drdata);
            check_output("err", err, exp_err);
        end
    end

    // Memory responder: mode 0 fixed latency, 1 random latency 0..3, 2 never ready.
    int            mem_mode = 0;
    int            mem_lat = 0;
    int            mem_wait = 0;
    int            rand_lat = 0;
    bit            use_fixed = 1'b0;
    logic [DW-1:0] fixed_rdata = '0;

    task automatic mem_drive();
        int lat;
        m_rdata = use_fixed ? fixed_rdata : DW'($urandom);
        if (!m_valid) begin
            mem_wait = 0;
            rand_lat = $urandom_range(0, 3);
            m_ready = 1'($urandom_range(0, 1));
        end else begin
            lat = (mem_mode == 1) ? rand_lat : mem_lat;
            if (mem_mode != 2 && mem_wait >= lat) begin
                m_ready = 1'b1;
            end else begin
                m_ready = 1'b0;
                mem_wait++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    // Random requesters: hold each request until retired, then maybe issue another.
    task automatic apply_stimulus();
        reset = ($urandom_range(0, 299) == 0);
        if (i_req ? i_ready : ($urandom_range(0, 3) == 0)) begin
            i_req = i_req ? 1'($urandom_range(0, 1)) : 1'b1;
            i_addr = AW'($urandom);
        end
        if (d_req ? d_ready : ($urandom_range(0, 2) == 0)) begin
            d_req = d_req ? 1'($urandom_range(0, 1)) : 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_addr = AW'($urandom);
            d_wdata = DW'($urandom);
        end
    endtask

    initial begin
        int icnt;
        int dcnt;
        int first;
        int vcnt;
        bit seen;
        bit prev_v;
        logic [DW-1:0] prev_d;
        int grants[$];
        int exp_grants[6];

        do_reset();
        chk_en = 1'b1;
        $display("[TB] reset released, starting directed tests");

        // Single fetch, zero-latency memory.
        mem_mode = 0; mem_lat = 0; use_fixed = 1'b1; fixed_rdata = 32'h0050_0093;
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        check_output("t1_m_valid", m_valid, 1);
        check_output("t1_m_addr", m_addr, 32'h40);
        check_output("t1_m_we", m_we, 0);
        tick();
        check_output("t1_i_ready", i_ready, 1);
        check_output("t1_i_rdata", i_rdata, 32'h0050_0093);
        check_output("t1_d_ready", d_ready, 0);
        i_req = 1'b0;
        tick();
        check_output("t1_i_ready_pulse", i_ready, 0);
        drain();

        // Simultaneous fetch and data read, 2-cycle memory.
        mem_lat = 2; use_fixed = 1'b0;
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick();
        check_output("t2_owner_first", owner, 2'b10);
        check_output("t2_addr_first", m_addr, 32'h100);
        icnt = 0; dcnt = 0; first = 0;
        for (int c = 0; c < 20; c++) begin
            if (d_ready) begin dcnt++; d_req = 1'b0; if (first == 0) first = 2; end
            if (i_ready) begin icnt++; i_req = 1'b0; if (first == 0) first = 1; end
            tick();
        end
        check_output("t2_d_ready_count", dcnt, 1);
        check_output("t2_i_ready_count", icnt, 1);
        check_output("t2_data_first", first, 2);
        drain();

        // Data store held off by a slow memory.
        mem_lat = 5;
        prev_d = d_rdata;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check_output("t3_m_valid", m_valid, 1);
            check_output("t3_m_we", m_we, 1);
            check_output("t3_m_addr", m_addr, 32'h200);
            check_output("t3_m_wdata", m_wdata, 32'hCAFE_F00D);
            check_output("t3_m_ready", m_ready, (c == 6));
        end
        tick();
        check_output("t3_d_ready", d_ready, 1);
        check_output("t3_d_rdata_kept", d_rdata, prev_d);
        drain();

        // Starvation guard with data held continuously.
        do_reset();
        mem_lat = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        i_req = 1'b1; i_addr = 32'h48;
        prev_v = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            tick();
            if (m_valid && !prev_v) grants.push_back(int'(owner));
            prev_v = m_valid;
            if (i_ready) i_req = 1'b0;
        end
        exp_grants = '{2, 2, 2, 2, 1, 2};
        for (int k = 0; k < 6; k++)
            check_output($sformatf("t4_grant%0d", k), (k < grants.size()) ? grants[k] : 99, exp_grants[k]);
        drain();

        // Memory timeout, then a normal access.
        mem_mode = 2;
        i_req = 1'b1; i_addr = 32'h80;
        vcnt = 0; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (m_valid) vcnt++;
            if (i_ready) begin
                seen = 1'b1;
                check_output("t5_i_rdata_fill", i_rdata, 32'hFFFF_FFFF);
                check_output("t5_err_set", err, 1);
                check_output("t5_valid_cycles", vcnt, 8);
                i_req = 1'b0;
            end
        end
        check_output("t5_ready_seen", seen, 1);
        mem_mode = 0; mem_lat = 1; use_fixed = 1'b1; fixed_rdata = 32'h1234_5678;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (d_ready) begin
                seen = 1'b1;
                check_output("t5_d_rdata", d_rdata, 32'h1234_5678);
                check_output("t5_err_sticky", err, 1);
                d_req = 1'b0;
            end
        end
        check_output("t5_next_ready_seen", seen, 1);
        drain();

        // Reset during a data grant.
        mem_mode = 2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        check_output("t6_owner_data", owner, 2'b10);
        reset = 1'b1;
        tick();
        check_output("t6_m_valid", m_valid, 0);
        check_output("t6_owner", owner, 0);
        check_output("t6_d_ready", d_ready, 0);
        check_output("t6_err", err, 0);
        check_output("t6_m_addr", m_addr, 0);
        reset = 1'b0; d_req = 1'b0;
        mem_mode = 0; mem_lat = 0; fixed_rdata = 32'hABCD_1234;
        i_req = 1'b1; i_addr = 32'h60;
        tick();
        check_output("t6_fetch_valid", m_valid, 1);
        check_output("t6_fetch_addr", m_addr, 32'h60);
        tick();
        check_output("t6_fetch_ready", i_ready, 1);
        check_output("t6_fetch_rdata", i_rdata, 32'hABCD_1234);
        drain();

        // Randomized traffic with random memory latency and occasional resets.
        $display("[TB] starting random traffic");
        mem_mode = 1; use_fixed = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            apply_stimulus();
        end
        reset = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch requester (read-only) and the data requester (read/write).
- Sits between the control/datapath and the unified memory; takes over from the i_or_d mux once fetch and data accesses may overlap.
- Per access, runs a grant/handshake FSM with a variable-latency memory handshake.
- Data has priority over fetch, with a starvation guard and a memory timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive data grants while fetch is pending; range 1..15.
- TIMEOUT, 255, max cycles waiting for m_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle pulse: i_rdata valid, request retired
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: d_rdata valid (reads), request retired
- d_rdata  out  DATA_W  load data
- m_valid  out  1  memory request valid; held until m_ready
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ready  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  DATA_W  memory read data
- owner  out  2  00 none, 01 fetch, 10 data
- err  out  1  sticky timeout flag

Behaviour:
Reset values:
- All outputs 0; rdata registers 0.
- FSM in IDLE; starve counter 0; timeout counter 0.
- Reset mid-access aborts the access: no ready pulse, m_valid drops on the next cycle.

States: IDLE, GRANT_I, GRANT_D, RESP.

IDLE:
- Samples i_req and d_req at the clock edge.
- Data wins if d_req=1, unless starve_cnt==STARVE_LIMIT and i_req=1; then fetch wins.
- On grant, the winner's fields are latched into m_addr, m_we and m_wdata. Fetch always has m_we=0 and m_wdata=0.
- Next state is GRANT_I or GRANT_D; owner updates to match.

Starve counter:
- +1 on each data grant taken while i_req=1; saturates at STARVE_LIMIT.
- Cleared on any fetch grant.
- Cleared on a data grant taken while i_req=0.

GRANT_x:
- m_valid=1, with latched fields held stable.
- When m_ready=1: capture m_rdata into the owner's rdata register, drop m_valid, go to RESP.
- Timeout counter increments each GRANT cycle without m_ready.
- If TIMEOUT≠0 and the count reaches TIMEOUT:
  - set err;
  - capture rdata as all-ones;
  - drop m_valid and go to RESP, so the requester still retires.

RESP:
- Exactly one cycle; x_ready=1 for the owner only.
- Clears owner and the timeout counter; next state is IDLE.
- Requests are not sampled in RESP. This prevents re-granting a request that is still high the cycle its ready is seen.

Latency:
- Request seen at edge 0 → m_valid in cycle 1.
- If m_ready arrives in cycle 1, x_ready is in cycle 2.
- Minimum 3 cycles per access; back-to-back throughput is 1 access per 3 cycles.

Other rules:
- Simultaneous i_req and d_req in IDLE resolve by the priority rule above. The loser stays pending with no side effects.
- Requests dropped before grant are ignored. A request withdrawn after grant completes anyway.
- m_rdata is ignored for writes; d_rdata keeps its previous value.
- rdata outputs hold their value until the next completion for the same port.
- err clears only on reset. The arbiter continues operating after a timeout.
- m_ready outside GRANT states is ignored.

Decomposition:
- Shared package: state encodings (IDLE=0, GRANT_I=1, GRANT_D=2, RESP=3) and owner encodings (NONE/FETCH/DATA).
- Shared package also holds the timeout fill value (all-ones).
- One natural sub-module: mem_arb_priority, the combinational winner select from (i_req, d_req, starve_cnt==STARVE_LIMIT).
- FSM, counters and latches live in the top module.

Test Plan:
1. Single fetch, i_addr=0x40, memory with 0-cycle latency returning 0x00500093:
   - m_valid in cycle 1 with m_addr=0x40, m_we=0;
   - i_ready in cycle 2 with i_rdata=0x00500093; d_ready never asserts.
2. Simultaneous i_req (0x44) and d_req read (0x100), 2-cycle memory:
   - data is granted first (owner=10, m_addr=0x100), then fetch;
   - exactly one d_ready, then one i_ready.
3. Data store, d_addr=0x200, d_wdata=0xCAFEF00D:
   - m_we=1 with fields held stable while m_ready is held low 5 cycles;
   - d_ready one cycle after m_ready; d_rdata unchanged.
4. d_req held continuously with i_req pending, STARVE_LIMIT=4:
   - exactly 4 data grants, then 1 fetch grant, then data resumes.
5. TIMEOUT=8 with m_ready tied 0:
   - m_valid high for 8 cycles, then err=1;
   - x_ready pulses with rdata=0xFFFFFFFF;
   - next access completes normally and err stays 1.
6. Reset asserted in a GRANT_D cycle:
   - next cycle all outputs are 0 and owner=00, with no d_ready pulse;
   - a subsequent fetch works with starve_cnt=0.
